// File: rtl/aline_tx_sequencer_if.sv
// Bus between the transmit sequencer, the config store and acquisition control.
// The sequencer side uses the master modport; the surrounding system uses slave.
interface aline_tx_sequencer_if;
   logic        start;
   logic        abort;
   logic        intaking_configs;
   logic        updating_delays;
   logic [7:0]  channel_select;
   logic [4:0]  aline_select;
   logic [31:0] pulse_shape;
   logic [15:0] ch0delay;
   logic [15:0] ch1delay;
   logic [15:0] ch2delay;
   logic [15:0] ch3delay;
   logic [15:0] ch4delay;
   logic [15:0] ch5delay;
   logic [15:0] ch6delay;
   logic [15:0] ch7delay;
   logic        rd_en;
   logic [3:0]  which_aline;
   logic [7:0]  tx_out;
   logic        busy;
   logic        aline_done;
   logic        image_done;

   modport master (
      input  start, abort, intaking_configs, updating_delays,
      input  channel_select, aline_select, pulse_shape,
      input  ch0delay, ch1delay, ch2delay, ch3delay,
      input  ch4delay, ch5delay, ch6delay, ch7delay,
      output rd_en, which_aline, tx_out, busy, aline_done, image_done
   );

   modport slave (
      output start, abort, intaking_configs, updating_delays,
      output channel_select, aline_select, pulse_shape,
      output ch0delay, ch1delay, ch2delay, ch3delay,
      output ch4delay, ch5delay, ch6delay, ch7delay,
      input  rd_en, which_aline, tx_out, busy, aline_done, image_done
   );
endinterface

// File: rtl/aline_tx_sequencer.sv
// Walks the A-lines of an image: fetches per-channel delays over the rd_en /
// updating_delays handshake, fires the pulse shape on each enabled channel, then idles a gap.
module aline_tx_sequencer #(
   parameter int unsigned GAP_CYCLES = 1000,
   parameter int unsigned HS_TIMEOUT = 15
) (
   input logic                  clk,
   input logic                  rst,
   aline_tx_sequencer_if.master bus
);
   localparam int unsigned HS_W  = (HS_TIMEOUT < 2) ? 1 : $clog2(HS_TIMEOUT);
   localparam int unsigned GAP_W = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES);

   typedef enum logic [2:0] {
      S_IDLE, S_REQ, S_WAIT_HI, S_WAIT_LO, S_LATCH, S_FIRE, S_GAP, S_DONE
   } state_t;

   state_t             r_state;
   logic [7:0]         r_mask;
   logic [31:0]        r_shape;
   logic [4:0]         r_n;
   logic [3:0]         r_aline;
   logic [15:0]        r_dly [8];
   logic [16:0]        r_end;
   logic [16:0]        r_fire_cnt;
   logic [HS_W-1:0]    r_hs_cnt;
   logic [GAP_W-1:0]   r_gap_cnt;
   logic               r_rd_en;
   logic               r_busy;
   logic               r_aline_done;
   logic               r_image_done;
   logic [7:0]         r_tx;

   logic [15:0]        w_dly_in [8];
   logic [15:0]        w_max;
   logic [16:0]        w_end;
   logic [16:0]        w_off [8];
   logic [7:0]         w_tx_next;
   logic [4:0]         w_n;
   logic               w_last;

   assign w_dly_in[0] = bus.ch0delay;
   assign w_dly_in[1] = bus.ch1delay;
   assign w_dly_in[2] = bus.ch2delay;
   assign w_dly_in[3] = bus.ch3delay;
   assign w_dly_in[4] = bus.ch4delay;
   assign w_dly_in[5] = bus.ch5delay;
   assign w_dly_in[6] = bus.ch6delay;
   assign w_dly_in[7] = bus.ch7delay;

   assign w_n    = (bus.aline_select > 5'd16) ? 5'd16 : bus.aline_select;
   assign w_last = ({1'b0, r_aline} == (r_n - 5'd1));

   // Firing ends once the latest enabled channel has shifted out all 32 bits.
   always_comb begin
      w_max = '0;
      for (int unsigned i = 0; i < 8; i++) begin
         if (r_mask[i] && (w_dly_in[i] > w_max))
            w_max = w_dly_in[i];
      end
      w_end = {1'b0, w_max} + 17'd32;
   end

   always_comb begin
      w_tx_next = '0;
      for (int unsigned i = 0; i < 8; i++) begin
         w_off[i] = r_fire_cnt - {1'b0, r_dly[i]};
         if (r_mask[i] && (r_fire_cnt >= {1'b0, r_dly[i]}) && (w_off[i] < 17'd32))
            w_tx_next[i] = r_shape[5'd31 - w_off[i][4:0]];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_mask       <= '0;
         r_shape      <= '0;
         r_n          <= '0;
         r_aline      <= '0;
         r_end        <= '0;
         r_fire_cnt   <= '0;
         r_hs_cnt     <= '0;
         r_gap_cnt    <= '0;
         r_rd_en      <= 1'b0;
         r_busy       <= 1'b0;
         r_aline_done <= 1'b0;
         r_image_done <= 1'b0;
         r_tx         <= '0;
         for (int unsigned i = 0; i < 8; i++)
            r_dly[i] <= '0;
      end else begin
         r_rd_en      <= 1'b0;
         r_aline_done <= 1'b0;
         r_image_done <= 1'b0;
         if (bus.abort) begin
            r_state <= S_IDLE;
            r_tx    <= '0;
            r_busy  <= 1'b0;
         end else begin
            case (r_state)
               S_IDLE: begin
                  if (bus.start && !bus.intaking_configs) begin
                     r_mask  <= bus.channel_select;
                     r_shape <= bus.pulse_shape;
                     r_n     <= w_n;
                     r_aline <= '0;
                     r_busy  <= 1'b1;
                     if (w_n == 5'd0) begin
                        r_state <= S_DONE;
                     end else begin
                        r_state <= S_REQ;
                        r_rd_en <= 1'b1;
                     end
                  end
               end
               S_REQ: begin
                  r_hs_cnt <= '0;
                  r_state  <= S_WAIT_HI;
               end
               S_WAIT_HI: begin
                  if (bus.updating_delays) begin
                     r_state <= S_WAIT_LO;
                  end else if (r_hs_cnt == HS_W'(HS_TIMEOUT - 1)) begin
                     r_state <= S_REQ;
                     r_rd_en <= 1'b1;
                  end else begin
                     r_hs_cnt <= r_hs_cnt + 1'b1;
                  end
               end
               S_WAIT_LO: begin
                  if (!bus.updating_delays)
                     r_state <= S_LATCH;
               end
               S_LATCH: begin
                  for (int unsigned i = 0; i < 8; i++)
                     r_dly[i] <= w_dly_in[i];
                  r_end      <= w_end;
                  r_fire_cnt <= '0;
                  r_state    <= S_FIRE;
               end
               S_FIRE: begin
                  r_tx       <= w_tx_next;
                  r_fire_cnt <= r_fire_cnt + 17'd1;
                  if (r_fire_cnt == r_end) begin
                     r_aline_done <= 1'b1;
                     r_gap_cnt    <= '0;
                     r_state      <= S_GAP;
                  end
               end
               S_GAP: begin
                  r_tx <= '0;
                  if (r_gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
                     if (w_last) begin
                        r_state <= S_DONE;
                     end else begin
                        r_aline <= r_aline + 4'd1;
                        r_rd_en <= 1'b1;
                        r_state <= S_REQ;
                     end
                  end else begin
                     r_gap_cnt <= r_gap_cnt + 1'b1;
                  end
               end
               S_DONE: begin
                  r_image_done <= 1'b1;
                  r_busy       <= 1'b0;
                  r_state      <= S_IDLE;
               end
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

   assign bus.rd_en       = r_rd_en;
   assign bus.which_aline = r_aline;
   assign bus.tx_out      = r_tx;
   assign bus.busy        = r_busy;
   assign bus.aline_done  = r_aline_done;
   assign bus.image_done  = r_image_done;
endmodule

// File: tb/tb_aline_tx_sequencer.sv
// Directed bench for aline_tx_sequencer: a delay-store model answers rd_en and a
// negedge monitor logs per-cycle outputs; each test task checks against hand-derived cycles.
module tb_aline_tx_sequencer;
   localparam int unsigned G  = 20;
   localparam int unsigned HS = 15;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   aline_tx_sequencer_if bus ();

   aline_tx_sequencer #(.GAP_CYCLES(G), .HS_TIMEOUT(HS)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   logic [15:0] tbl [16][8];
   int          model_ignore = 0;

   int          rd_q [$];
   int          wa_q [$];
   int          ad_q [$];
   int          id_q [$];
   logic [7:0]  h_tx   [int];
   logic        h_busy [int];
   logic [3:0]  h_wa   [int];

   // Config store model: answers an rd_en with two cycles of updating_delays.
   initial begin
      bus.updating_delays = 1'b0;
      {bus.ch0delay, bus.ch1delay, bus.ch2delay, bus.ch3delay} = '0;
      {bus.ch4delay, bus.ch5delay, bus.ch6delay, bus.ch7delay} = '0;
      forever begin
         @(negedge clk);
         if (bus.rd_en === 1'b1) begin
            if (model_ignore > 0) begin
               model_ignore--;
            end else begin
               bus.ch0delay = tbl[bus.which_aline][0];
               bus.ch1delay = tbl[bus.which_aline][1];
               bus.ch2delay = tbl[bus.which_aline][2];
               bus.ch3delay = tbl[bus.which_aline][3];
               bus.ch4delay = tbl[bus.which_aline][4];
               bus.ch5delay = tbl[bus.which_aline][5];
               bus.ch6delay = tbl[bus.which_aline][6];
               bus.ch7delay = tbl[bus.which_aline][7];
               bus.updating_delays = 1'b1;
               repeat (2) @(negedge clk);
               bus.updating_delays = 1'b0;
            end
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         h_tx[cyc]   = bus.tx_out;
         h_busy[cyc] = bus.busy;
         h_wa[cyc]   = bus.which_aline;
         if (bus.rd_en === 1'b1) begin
            rd_q.push_back(cyc);
            wa_q.push_back(int'(bus.which_aline));
         end
         if (bus.aline_done === 1'b1) ad_q.push_back(cyc);
         if (bus.image_done === 1'b1) id_q.push_back(cyc);
      end
   end

   task automatic clear_logs();
      repeat (3) @(negedge clk);
      rd_q.delete(); wa_q.delete(); ad_q.delete(); id_q.delete();
      h_tx.delete(); h_busy.delete(); h_wa.delete();
      model_ignore = 0;
      for (int a = 0; a < 16; a++)
         for (int c = 0; c < 8; c++)
            tbl[a][c] = '0;
   endtask

   task automatic pulse_start(output int s);
      @(negedge clk);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      s = cyc;
   endtask

   task automatic wait_done(input int budget, input string name);
      int n = 0;
      while (id_q.size() == 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (id_q.size() == 0) begin
         errors++;
         $display("FAIL %s_timeout: image_done not seen within %0d cycles", name, budget);
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      checks++;
      if ({bus.rd_en, bus.which_aline, bus.tx_out, bus.busy, bus.aline_done, bus.image_done} !== 17'd0) begin
         errors++;
         $display("FAIL reset_held: outputs=%h required 0",
                  {bus.rd_en, bus.which_aline, bus.tx_out, bus.busy, bus.aline_done, bus.image_done});
      end
      rst = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({bus.rd_en, bus.which_aline, bus.tx_out, bus.busy, bus.aline_done, bus.image_done} !== 17'd0) begin
         errors++;
         $display("FAIL reset_idle: outputs=%h required 0",
                  {bus.rd_en, bus.which_aline, bus.tx_out, bus.busy, bus.aline_done, bus.image_done});
      end
   endtask

   task automatic test_single();
      int s;
      logic [31:0] got;
      logic [7:0]  others;
      clear_logs();
      bus.aline_select = 5'd1; bus.channel_select = 8'h01; bus.pulse_shape = 32'hA500_0000;
      tbl[0][0] = 16'd3;
      pulse_start(s);
      repeat (2) @(negedge clk);
      bus.channel_select = 8'hFF; bus.pulse_shape = 32'h0;
      wait_done(200, "single");
      got = '0;
      for (int k = 0; k < 32; k++) got[31-k] = h_tx[s+8+k][0];
      others = '0;
      for (int c = s; c <= s + 60; c++) others |= {h_tx[c][7:1], 1'b0};
      checks++;
      if (rd_q.size() != 1 || rd_q[0] != s) begin
         errors++; $display("FAIL single_rd_en: count=%0d required 1 at cycle %0d", rd_q.size(), s);
      end
      checks++;
      if (h_tx[s+7][0] !== 1'b0 || got !== 32'hA500_0000 || h_tx[s+40][0] !== 1'b0) begin
         errors++; $display("FAIL single_shape: got=%h required a5000000", got);
      end
      checks++;
      if (others !== 8'h00) begin
         errors++; $display("FAIL single_snapshot: other channels=%h required 00", others);
      end
      checks++;
      if (ad_q.size() != 1 || ad_q[0] != s + 40) begin
         errors++; $display("FAIL single_aline_done: count=%0d required 1 at cycle %0d", ad_q.size(), s + 40);
      end
      checks++;
      if (id_q.size() != 1 || id_q[0] != s + 41 + int'(G) || h_busy[s+41+int'(G)] !== 1'b0) begin
         errors++; $display("FAIL single_image_done: count=%0d required 1 at cycle %0d", id_q.size(), s + 41 + int'(G));
      end
   endtask

   task automatic test_staggered();
      int s;
      clear_logs();
      bus.aline_select = 5'd1; bus.channel_select = 8'hFF; bus.pulse_shape = 32'hFFFF_FFFF;
      for (int c = 0; c < 8; c++) tbl[0][c] = 16'(10 * c);
      pulse_start(s);
      wait_done(300, "stagger");
      for (int ch = 0; ch < 8; ch++) begin
         int first = -1;
         int cnt   = 0;
         for (int c = s; c <= s + 120; c++) begin
            if (h_tx[c][ch] === 1'b1) begin
               if (first < 0) first = c;
               cnt++;
            end
         end
         checks++;
         if (first != s + 5 + 10 * ch || cnt != 32) begin
            errors++;
            $display("FAIL stagger_ch%0d: first=%0d count=%0d required first=%0d count=32",
                     ch, first - s, cnt, 5 + 10 * ch);
         end
      end
      checks++;
      if (ad_q.size() != 1 || ad_q[0] != s + 107) begin
         errors++; $display("FAIL stagger_end: aline_done count=%0d required 1 at +107", ad_q.size());
      end
   endtask

   task automatic test_multi_aline();
      int s;
      int exp_rd [3];
      int exp_ad [3];
      clear_logs();
      bus.aline_select = 5'd3; bus.channel_select = 8'h01; bus.pulse_shape = 32'hF000_0000;
      tbl[0][0] = 16'd1; tbl[1][0] = 16'd5; tbl[2][0] = 16'd9;
      exp_rd = '{0, 58, 120};
      exp_ad = '{38, 100, 166};
      pulse_start(s);
      repeat (70) @(negedge clk);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      wait_done(400, "multi");
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (rd_q.size() != 3 || rd_q[k] != s + exp_rd[k] || wa_q[k] != k || h_wa[s+exp_ad[k]] !== 4'(k)) begin
            errors++;
            $display("FAIL multi_aline%0d: rd_en count=%0d required 3 at +%0d with which_aline=%0d",
                     k, rd_q.size(), exp_rd[k], k);
         end
         checks++;
         if (ad_q.size() != 3 || ad_q[k] != s + exp_ad[k]) begin
            errors++; $display("FAIL multi_done%0d: aline_done count=%0d required 3 at +%0d", k, ad_q.size(), exp_ad[k]);
         end
      end
      checks++;
      if (h_tx[s+67][0] !== 1'b0 || h_tx[s+68][0] !== 1'b1) begin
         errors++; $display("FAIL multi_fire1: tx0=%b%b required 01", h_tx[s+67][0], h_tx[s+68][0]);
      end
      checks++;
      if (id_q.size() != 1 || id_q[0] != s + 187 || h_busy[s+187] !== 1'b0 || h_busy[s+186] !== 1'b1) begin
         errors++; $display("FAIL multi_image_done: count=%0d required 1 at +187 with busy falling", id_q.size());
      end
   endtask

   task automatic test_zero_alines();
      int s;
      clear_logs();
      bus.aline_select = 5'd0; bus.channel_select = 8'h01;
      pulse_start(s);
      wait_done(20, "zero");
      checks++;
      if (rd_q.size() != 0 || id_q.size() != 1 || id_q[0] != s + 1) begin
         errors++; $display("FAIL zero_alines: rd_en=%0d image_done=%0d required 0 and 1", rd_q.size(), id_q.size());
      end
   endtask

   task automatic test_empty_mask();
      int s;
      logic [7:0] any;
      clear_logs();
      bus.aline_select = 5'd1; bus.channel_select = 8'h00; bus.pulse_shape = 32'hFFFF_FFFF;
      for (int c = 0; c < 8; c++) tbl[0][c] = 16'd50;
      pulse_start(s);
      wait_done(200, "mask0");
      any = '0;
      for (int c = s; c <= s + 55; c++) any |= h_tx[c];
      checks++;
      if (any !== 8'h00) begin
         errors++; $display("FAIL mask0_tx: tx_out=%h required 00", any);
      end
      checks++;
      if (ad_q.size() != 1 || ad_q[0] != s + 37) begin
         errors++; $display("FAIL mask0_end: aline_done count=%0d required 1 at +37", ad_q.size());
      end
   endtask

   task automatic test_clamp();
      int s;
      clear_logs();
      bus.aline_select = 5'd20; bus.channel_select = 8'h00;
      pulse_start(s);
      wait_done(1500, "clamp");
      checks++;
      if (rd_q.size() != 16 || wa_q[15] != 15 || rd_q[15] != s + 15 * 57) begin
         errors++; $display("FAIL clamp_count: rd_en count=%0d required 16", rd_q.size());
      end
      checks++;
      if (id_q.size() != 1 || id_q[0] != s + 913) begin
         errors++; $display("FAIL clamp_done: image_done count=%0d required 1 at +913", id_q.size());
      end
   endtask

   task automatic test_max_delay();
      int s;
      int first = -1;
      int cnt   = 0;
      logic ch0 = 1'b0;
      clear_logs();
      bus.aline_select = 5'd1; bus.channel_select = 8'h03; bus.pulse_shape = 32'hFFFF_FFFF;
      tbl[0][0] = 16'hFFFF; tbl[0][1] = 16'd16;
      pulse_start(s);
      repeat (300) @(negedge clk);
      for (int c = s; c <= s + 298; c++) begin
         ch0 |= h_tx[c][0];
         if (h_tx[c][1] === 1'b1) begin
            if (first < 0) first = c;
            cnt++;
         end
      end
      checks++;
      if (ad_q.size() != 0 || h_busy[s+298] !== 1'b1) begin
         errors++; $display("FAIL maxdly_nowrap: aline_done count=%0d required 0 (firing still running)", ad_q.size());
      end
      checks++;
      if (first != s + 21 || cnt != 32 || ch0 !== 1'b0) begin
         errors++; $display("FAIL maxdly_fire: ch1 first=%0d count=%0d required 21 and 32", first - s, cnt);
      end
      bus.abort = 1'b1;
      @(negedge clk);
      bus.abort = 1'b0;
      checks++;
      if (bus.busy !== 1'b0 || bus.tx_out !== 8'h00) begin
         errors++; $display("FAIL maxdly_abort: busy=%b required 0", bus.busy);
      end
   endtask

   task automatic test_timeout();
      int s;
      clear_logs();
      bus.aline_select = 5'd1; bus.channel_select = 8'h01; bus.pulse_shape = 32'h8000_0000;
      model_ignore = 1;
      pulse_start(s);
      wait_done(200, "timeout");
      checks++;
      if (rd_q.size() != 2 || rd_q[0] != s || rd_q[1] != s + int'(HS) + 1) begin
         errors++; $display("FAIL timeout_rereq: rd_en count=%0d required 2 spaced %0d", rd_q.size(), HS + 1);
      end
      checks++;
      if (id_q.size() != 1 || id_q[0] != s + 74) begin
         errors++; $display("FAIL timeout_done: image_done count=%0d required 1 at +74", id_q.size());
      end
   endtask

   task automatic test_abort();
      int s;
      clear_logs();
      bus.aline_select = 5'd1; bus.channel_select = 8'h01; bus.pulse_shape = 32'hFFFF_FFFF;
      pulse_start(s);
      repeat (10) @(negedge clk);
      bus.abort = 1'b1;
      @(negedge clk);
      bus.abort = 1'b0;
      repeat (60) @(negedge clk);
      checks++;
      if (h_tx[s+10][0] !== 1'b1 || h_tx[s+11] !== 8'h00 || h_busy[s+11] !== 1'b0) begin
         errors++; $display("FAIL abort_fire: tx=%h busy=%b required 00 and 0", h_tx[s+11], h_busy[s+11]);
      end
      checks++;
      if (ad_q.size() != 0 || id_q.size() != 0) begin
         errors++; $display("FAIL abort_pulses: aline_done=%0d image_done=%0d required 0", ad_q.size(), id_q.size());
      end
   endtask

   task automatic test_rst_gap();
      int s;
      clear_logs();
      bus.aline_select = 5'd2; bus.channel_select = 8'h00;
      pulse_start(s);
      repeat (100) @(negedge clk);
      checks++;
      if (bus.busy !== 1'b1 || bus.which_aline !== 4'd1) begin
         errors++; $display("FAIL rst_pre: busy=%b which_aline=%0d required 1 and 1", bus.busy, bus.which_aline);
      end
      #1 rst = 1'b1;
      #1;
      checks++;
      if ({bus.rd_en, bus.which_aline, bus.tx_out, bus.busy, bus.aline_done, bus.image_done} !== 17'd0) begin
         errors++; $display("FAIL rst_async: outputs=%h required 0",
                            {bus.rd_en, bus.which_aline, bus.tx_out, bus.busy, bus.aline_done, bus.image_done});
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_intaking();
      logic b = 1'b0;
      clear_logs();
      bus.aline_select = 5'd1; bus.channel_select = 8'h01;
      @(negedge clk);
      bus.intaking_configs = 1'b1;
      bus.start = 1'b1;
      repeat (5) @(negedge clk);
      bus.start = 1'b0;
      bus.intaking_configs = 1'b0;
      repeat (5) @(negedge clk);
      foreach (h_busy[c]) b |= h_busy[c];
      checks++;
      if (rd_q.size() != 0 || b !== 1'b0) begin
         errors++; $display("FAIL intaking_ignore: rd_en=%0d busy_seen=%b required 0 and 0", rd_q.size(), b);
      end
   endtask

   initial begin
      bus.start = 1'b0; bus.abort = 1'b0; bus.intaking_configs = 1'b0;
      bus.channel_select = '0; bus.aline_select = '0; bus.pulse_shape = '0;
      test_reset();
      test_single();
      test_staggered();
      test_multi_aline();
      test_zero_alines();
      test_empty_mask();
      test_clamp();
      test_max_delay();
      test_timeout();
      test_abort();
      test_rst_gap();
      test_intaking();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
